branch_predictor: RTL

- Dynamic branch predictor with branch target buffer (BTB) for the 5-stage pipelined CPU. Replaces the static "predict not-taken, redirect from ID" scheme.
- Sits beside PC/Instruction_Memory in IF and is looked up with the current PC in the same cycle.
- ID-stage branch/jump resolution writes the outcome back through the update port.
- Parametrised in address width, table depth and counter width. Keeps mispredict and update statistics.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/sat_counter_next.sv | 30 +++
 rtl/branch_predictor.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the branch predictor and its helpers.
//   PC_INC          : sequential instruction stride in bytes
//   ADDR_W_DEF      : default PC / target width
//   clog2()         : ceiling log2, usable in parameter expressions
//   weak_taken()    : counter encoding MSB=1, other bits 0
//   weak_not_taken(): counter encoding MSB=0, other bits 1 (0 when width is 1)
package cpu_pkg;

   localparam int PC_INC     = 4;
   localparam int ADDR_W_DEF = 32;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   function automatic int weak_taken(input int cnt_w);
      return 1 << (cnt_w - 1);
   endfunction

   function automatic int weak_not_taken(input int cnt_w);
      return (1 << (cnt_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/sat_counter_next.sv
// Combinational next-value for a W-bit saturating up/down counter.
//   cnt      : current value
//   en       : step enable (cnt_next == cnt when low)
//   up       : 1 = increment, 0 = decrement
//   cnt_next : next value, clamped to all-ones on increment and 0 on decrement
module sat_counter_next #(
   parameter int W = 2
) (
   input  logic [W-1:0] cnt,
   input  logic         en,
   input  logic         up,
   output logic [W-1:0] cnt_next
);

   always_comb begin
      cnt_next = cnt;
      if (en) begin
         if (up) begin
            if (cnt != {W{1'b1}}) begin
               cnt_next = cnt + W'(1);
            end
         end else begin
            if (cnt != {W{1'b0}}) begin
               cnt_next = cnt - W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor with a direct-mapped branch target buffer.
// Looked up combinationally with the IF-stage PC; trained by ID-stage
// branch resolution through the update port.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   start_i               : run enable; low forces no prediction and freezes state
//   flush_i               : clear every valid bit (contents are kept)
//   lookup_pc_i           : IF-stage PC
//   pred_taken_o          : predicted taken for lookup_pc_i
//   pred_target_o         : predicted next PC
//   upd_valid_i ... upd_pred_taken_i : resolved branch/jump and the prediction it got
//   update_count_o        : accepted updates (saturating)
//   mispred_count_o       : accepted updates whose prediction was wrong (saturating)
module branch_predictor
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] lookup_pc_i,
   output logic              pred_taken_o,
   output logic [ADDR_W-1:0] pred_target_o,
   input  logic              upd_valid_i,
   input  logic [ADDR_W-1:0] upd_pc_i,
   input  logic              upd_taken_i,
   input  logic [ADDR_W-1:0] upd_target_i,
   input  logic              upd_pred_taken_i,
   output logic [31:0]       update_count_o,
   output logic [31:0]       mispred_count_o
);

   localparam int IDX_W = clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(weak_taken(CNT_W));
   localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(weak_not_taken(CNT_W));

   // Table storage is kept in flops: the lookup path is asynchronous.
   logic              valid_reg  [ENTRIES];
   logic [TAG_W-1:0]  tag_reg    [ENTRIES];
   logic [ADDR_W-1:0] target_reg [ENTRIES];
   logic [CNT_W-1:0]  cnt_reg    [ENTRIES];

   logic [31:0] update_count_reg;
   logic [31:0] mispred_count_reg;

   // ---------------- lookup ----------------
   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;

   assign lk_idx = lookup_pc_i[IDX_W+1:2];
   assign lk_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];
   assign lk_hit = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag) && start_i && !rst_i;

   assign pred_taken_o  = lk_hit && cnt_reg[lk_idx][CNT_W-1];
   assign pred_target_o = pred_taken_o ? target_reg[lk_idx]
                                       : lookup_pc_i + ADDR_W'(PC_INC);

   // ---------------- update ----------------
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;
   logic             upd_accept;
   logic             upd_mispred;
   logic [CNT_W-1:0] cnt_next;
   logic [31:0]      update_count_next;
   logic [31:0]      mispred_count_next;

   assign upd_idx     = upd_pc_i[IDX_W+1:2];
   assign upd_tag     = upd_pc_i[ADDR_W-1:IDX_W+2];
   assign upd_hit     = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
   // Flush and reset both take precedence over a presented update.
   assign upd_accept  = upd_valid_i && start_i && !flush_i && !rst_i;
   assign upd_mispred = upd_pred_taken_i != upd_taken_i;

   // Byte-offset bits of the PCs do not participate in indexing.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = &{1'b0, lookup_pc_i[1:0], upd_pc_i[1:0]};

   sat_counter_next #(.W(CNT_W)) u_dir_cnt (
      .cnt      (cnt_reg[upd_idx]),
      .en       (1'b1),
      .up       (upd_taken_i),
      .cnt_next (cnt_next)
   );

   sat_counter_next #(.W(32)) u_update_stat (
      .cnt      (update_count_reg),
      .en       (upd_accept),
      .up       (1'b1),
      .cnt_next (update_count_next)
   );

   sat_counter_next #(.W(32)) u_mispred_stat (
      .cnt      (mispred_count_reg),
      .en       (upd_accept && upd_mispred),
      .up       (1'b1),
      .cnt_next (mispred_count_next)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_reg[i]  <= 1'b0;
            tag_reg[i]    <= '0;
            target_reg[i] <= '0;
            cnt_reg[i]    <= CNT_WNT;
         end
         update_count_reg  <= '0;
         mispred_count_reg <= '0;
      end else begin
         if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
               valid_reg[i] <= 1'b0;
            end
         end
         if (upd_accept) begin
            if (upd_hit) begin
               cnt_reg[upd_idx] <= cnt_next;
               if (upd_taken_i) begin
                  target_reg[upd_idx] <= upd_target_i;
               end
            end else if (upd_taken_i) begin
               // Allocate, evicting whatever alias occupied this slot.
               valid_reg[upd_idx]  <= 1'b1;
               tag_reg[upd_idx]    <= upd_tag;
               target_reg[upd_idx] <= upd_target_i;
               cnt_reg[upd_idx]    <= CNT_WT;
            end
         end
         update_count_reg  <= update_count_next;
         mispred_count_reg <= mispred_count_next;
      end
   end

   assign update_count_o  = update_count_reg;
   assign mispred_count_o = mispred_count_reg;

endmodule
